// File: rtl/jk_excitation_driver_if.sv
// Request and flop-bank signals of jk_excitation_driver.
// The master side is the sequencer together with the JK bank; the slave side is the driver.
interface jk_excitation_driver_if #(
    parameter int N = 4
);
    logic [N-1:0] target;
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] Q_fb;
    logic [N-1:0] J;
    logic [N-1:0] K;
    logic         en;
    logic         done;
    logic         err;

    modport master (
        output target,
        output req_valid,
        output Q_fb,
        input  req_ready,
        input  J,
        input  K,
        input  en,
        input  done,
        input  err
    );

    modport slave (
        input  target,
        input  req_valid,
        input  Q_fb,
        output req_ready,
        output J,
        output K,
        output en,
        output done,
        output err
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// Drives J/K/en of a JK flop bank toward an accepted target word and reports done or err.
// Define JK_TOGGLE_DRIVE_EN to drive differing bits with J=K=1 (toggle) instead of set/reset.
module jk_excitation_driver #(
    parameter int N       = 4,
    parameter int TIMEOUT = 3
) (
    input logic                  clk,
    input logic                  R,
    jk_excitation_driver_if.slave bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRIVE = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    logic [2:0]   state_q, state_d;
    logic [N-1:0] tgt_q, tgt_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [N-1:0] j_q, j_d;
    logic [N-1:0] k_q, k_d;
    logic         req_ready_q, req_ready_d;
    logic         en_q, en_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    function automatic logic [N-1:0] excite_j(input logic [N-1:0] q, input logic [N-1:0] t);
`ifdef JK_TOGGLE_DRIVE_EN
        return q ^ t;
`else
        return t & ~q;
`endif
    endfunction

    function automatic logic [N-1:0] excite_k(input logic [N-1:0] q, input logic [N-1:0] t);
`ifdef JK_TOGGLE_DRIVE_EN
        return q ^ t;
`else
        return q & ~t;
`endif
    endfunction

    // Next-state and next-output logic; J/K for the DRIVE cycle are formed at the accept
    // edge because Q_fb cannot move before the bank sees en.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        j_d     = '0;
        k_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    tgt_d   = bus.target;
                    j_d     = excite_j(bus.Q_fb, bus.target);
                    k_d     = excite_k(bus.Q_fb, bus.target);
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                cnt_d   = 4'd0;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (bus.Q_fb == tgt_q) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = ST_CHECK;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        en_d        = (state_d == ST_DRIVE);
        done_d      = (state_d == ST_DONE);
        err_d       = (state_d == ST_ERR);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (R) begin
            state_q     <= ST_IDLE;
            tgt_q       <= '0;
            cnt_q       <= 4'd0;
            j_q         <= '0;
            k_q         <= '0;
            req_ready_q <= 1'b1;
            en_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
            j_q         <= j_d;
            k_q         <= k_d;
            req_ready_q <= req_ready_d;
            en_q        <= en_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.J         = j_q;
    assign bus.K         = k_q;
    assign bus.en        = en_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Randomized bench for jk_excitation_driver against a transaction-level timeline model
// and a behavioural JK bank that can respond late or be stuck.
module tb_jk_excitation_driver;

    localparam int N       = 4;
    localparam int TIMEOUT = 3;

    typedef struct packed {
        logic         ready;
        logic         en;
        logic         done;
        logic         err;
        logic [N-1:0] j;
        logic [N-1:0] k;
    } exp_t;

    logic clk = 1'b0;
    logic R;
    always #5 clk = ~clk;

    jk_excitation_driver_if #(.N(N)) bus();

    jk_excitation_driver #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .R   (R),
        .bus (bus)
    );

    exp_t         q_exp[$];
    exp_t         cur;
    int           checks   = 0;
    int           failures = 0;
    bit           chk_on   = 1'b0;
    logic         bank_en  = 1'b0;
    logic [N-1:0] bank_j   = '0;
    logic [N-1:0] bank_k   = '0;
    int           pend_cnt = 0;
    logic [N-1:0] pend_val = '0;
    bit           cfg_stuck = 1'b0;
    int           cfg_d     = 0;
    bit           mode_stuck;
    int           mode_d;

    function automatic exp_t idle_exp();
        exp_t e;
        e = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    function automatic exp_t dut_out();
        exp_t e;
        e.ready = bus.req_ready;
        e.en    = bus.en;
        e.done  = bus.done;
        e.err   = bus.err;
        e.j     = bus.J;
        e.k     = bus.K;
        return e;
    endfunction

    function automatic logic [N-1:0] spec_j(input logic [N-1:0] q, input logic [N-1:0] t);
`ifdef JK_TOGGLE_DRIVE_EN
        return q ^ t;
`else
        return t & ~q;
`endif
    endfunction

    function automatic logic [N-1:0] spec_k(input logic [N-1:0] q, input logic [N-1:0] t);
`ifdef JK_TOGGLE_DRIVE_EN
        return q ^ t;
`else
        return q & ~t;
`endif
    endfunction

    // Characteristic equation of a JK flop: Q+ = J~Q | ~K Q.
    function automatic logic [N-1:0] jk_apply(input logic [N-1:0] q, input logic [N-1:0] j,
                                              input logic [N-1:0] k);
        return (j & ~q) | (~k & q);
    endfunction

    task automatic chk_lit(input string name, input logic [2*N+3:0] act, input logic [2*N+3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock edge: update model expectations and the bank from the values at that edge.
    task automatic tick();
        logic [N-1:0] q_edge;
        exp_t e;
        int kk;
        int m;
        @(posedge clk);
        #1;
        q_edge = bus.Q_fb;
        if (R) begin
            q_exp.delete();
            pend_cnt = 0;
            cur = idle_exp();
        end else begin
            if (bus.req_valid && cur.ready) begin
                cfg_stuck = mode_stuck;
                cfg_d     = mode_d;
                if (bus.target == q_edge) kk = 0;
                else if (cfg_stuck)       kk = 1000;
                else                      kk = cfg_d;
                e = '0;
                e.en = 1'b1;
                e.j  = spec_j(q_edge, bus.target);
                e.k  = spec_k(q_edge, bus.target);
                q_exp.push_back(e);
                m = (kk < TIMEOUT) ? kk + 1 : TIMEOUT;
                e = '0;
                repeat (m) q_exp.push_back(e);
                e.done = (kk < TIMEOUT);
                e.err  = !(kk < TIMEOUT);
                q_exp.push_back(e);
            end
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) bus.Q_fb = pend_val;
            end
            if (bank_en && !cfg_stuck) begin
                pend_val = jk_apply(q_edge, bank_j, bank_k);
                if (cfg_d == 0) bus.Q_fb = pend_val;
                else            pend_cnt = cfg_d;
            end
            cur = (q_exp.size() != 0) ? q_exp.pop_front() : idle_exp();
        end
    endtask

    // Per-cycle comparison against the model; also what the bank sees of en/J/K.
    always @(negedge clk) begin
        exp_t act;
        act     = dut_out();
        bank_en = bus.en;
        bank_j  = bus.J;
        bank_k  = bus.K;
        if (chk_on) begin
            checks++;
            if (act !== cur) begin
                failures++;
                $display("FAIL cycle_compare t=%0t actual rdy=%b en=%b done=%b err=%b J=%b K=%b required rdy=%b en=%b done=%b err=%b J=%b K=%b",
                         $time, act.ready, act.en, act.done, act.err, act.j, act.k,
                         cur.ready, cur.en, cur.done, cur.err, cur.j, cur.k);
            end
        end
    end

    initial begin
        R = 1'b1;
        bus.req_valid = 1'b0;
        bus.target = '0;
        bus.Q_fb = '0;
        mode_stuck = 1'b0;
        mode_d = 0;
        cur = idle_exp();
        tick();
        chk_on = 1'b1;
        tick();
        R = 1'b0;
        chk_lit("reset_outputs", dut_out(), {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000});

        // set 1010 from 0000 with an ideal bank
        bus.Q_fb = 4'b0000;
        bus.target = 4'b1010;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk_lit("drive_en", {10'd0, bus.en}, 11'd1);
        chk_lit("drive_J", {7'd0, bus.J}, {7'd0, 4'b1010});
`ifdef JK_TOGGLE_DRIVE_EN
        chk_lit("drive_K", {7'd0, bus.K}, {7'd0, 4'b1010});
`else
        chk_lit("drive_K", {7'd0, bus.K}, {7'd0, 4'b0000});
`endif
        tick();
        chk_lit("check_en_low", {10'd0, bus.en}, 11'd0);
        tick();
        chk_lit("done_at_3", {10'd0, bus.done}, 11'd1);
        tick();
        chk_lit("ready_at_4", {9'd0, bus.req_ready, bus.done}, {9'd0, 1'b1, 1'b0});

        // 1111 -> 0110
        bus.Q_fb = 4'b1111;
        bus.target = 4'b0110;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
`ifdef JK_TOGGLE_DRIVE_EN
        chk_lit("drive2_JK", {3'd0, bus.J, bus.K}, {3'd0, 4'b1001, 4'b1001});
`else
        chk_lit("drive2_JK", {3'd0, bus.J, bus.K}, {3'd0, 4'b0000, 4'b1001});
`endif
        repeat (3) tick();

        // stuck bank: three CHECK cycles then err
        bus.Q_fb = 4'b0000;
        bus.target = 4'b0001;
        mode_stuck = 1'b1;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        repeat (3) tick();
        chk_lit("no_err_at_4", {9'd0, bus.err, bus.done}, 11'd0);
        tick();
        chk_lit("err_at_5", {9'd0, bus.err, bus.done}, {9'd0, 1'b1, 1'b0});
        tick();
        chk_lit("idle_after_err", {9'd0, bus.req_ready, bus.err}, {9'd0, 1'b1, 1'b0});

        // reset during CHECK drops the request
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        R = 1'b1;
        tick();
        R = 1'b0;
        chk_lit("reset_mid_check", dut_out(), {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000});
        repeat (4) tick();
        mode_stuck = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            R = ($urandom_range(0, 39) == 0);
            bus.req_valid = ($urandom_range(0, 2) != 0);
            bus.target = N'($urandom);
            mode_stuck = ($urandom_range(0, 5) == 0);
            mode_d = int'($urandom_range(0, 4));
            if (q_exp.size() == 0 && cur.ready && pend_cnt == 0 && $urandom_range(0, 3) == 0)
                bus.Q_fb = N'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Drive-side controller for a bank of N JK flip-flops that have an enable input.
- Accepts a target state word through a valid/ready handshake.
- Derives the J/K excitation for every bit from the flops' fed-back Q and issues a single enable pulse.
- Checks that the bank reaches the target, then reports done or err. Sits between sequencing logic and the JK register bank.

Parameters:
N, 4, number of JK flip-flops driven (width of target, Q_fb, J, K)
TIMEOUT, 3, number of CHECK cycles allowed for Q_fb to match before err; legal range 1..15

Ports:
clk  input  1  system clock, all state updates on rising edge
R  input  1  synchronous active-high reset, sampled on rising edge of clk
target  input  N  requested next state of the flop bank
req_valid  input  1  target is valid
req_ready  output  1  block can accept a request
Q_fb  input  N  Q outputs fed back from the JK flop bank
J  output  N  J inputs to the flop bank
K  output  N  K inputs to the flop bank
en  output  1  enable to the flop bank, one-cycle pulse
done  output  1  one-cycle pulse: bank reached target
err  output  1  one-cycle pulse: bank failed to reach target within TIMEOUT

Behaviour:
- All outputs are registered. The block has one clock (clk) and a synchronous active-high reset (R).
- Reset (R=1 at a rising edge):
  - state=IDLE, latched target=0, timeout counter=0.
  - J=0, K=0, en=0, done=0, err=0, req_ready=1 from the next cycle.
  - R overrides any state, including mid-DRIVE or mid-CHECK. An interrupted request is dropped with no done/err.
- States: IDLE, DRIVE, CHECK, DONE, ERR.
- IDLE:
  - req_ready=1; J=K=0; en=0.
  - On req_valid&req_ready: latch target into tgt_q and go to DRIVE.
  - req_ready=0 in every other state. req_valid is ignored outside IDLE.
- DRIVE (exactly 1 cycle):
  - en=1.
  - Per bit i, from the current Q_fb[i] and tgt_q[i]:
    - Q=0, tgt=0 -> J=0, K=0
    - Q=0, tgt=1 -> J=1, K=0
    - Q=1, tgt=0 -> J=0, K=1
    - Q=1, tgt=1 -> J=0, K=0
  - J=K=1 is never driven (without the optional feature).
  - Next state: CHECK, with counter cleared to 0.
  - If tgt_q already equals Q_fb, DRIVE still occurs with J=K=0 and en=1. No bypass.
- CHECK:
  - en=0, J=K=0.
  - If Q_fb==tgt_q: go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 while still mismatching, go to ERR.
  - Q_fb is sampled every CHECK cycle. A match on the last allowed cycle takes priority over timeout.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1 for one cycle, then IDLE. tgt_q is retained until the next accept.
- Latency with an ideal flop bank (Q updates at the edge ending DRIVE):
  - Accept edge at cycle 0.
  - en high in cycle 1.
  - Match seen in cycle 2.
  - done high in cycle 3.
  - req_ready high again in cycle 4, so the throughput is one request per 4 cycles.
- done and err are never asserted together. en is never high for more than one consecutive cycle.

Optional Feature:
- Macro JK_TOGGLE_DRIVE_EN.
- When defined: any bit whose Q_fb differs from tgt_q is driven J=1, K=1 (toggle) instead of set/reset. Unchanged bits stay J=K=0.
- When undefined: the set/reset excitation above is used and J&K is always 0.
- Timing and FSM are identical in both builds.

Test Plan:
- R=1 for 2 cycles, then R=0 -> J=K=0, en=done=err=0, req_ready=1.
- Q_fb=4'b0000, target=4'b1010, req_valid pulse -> in the DRIVE cycle J=4'b1010, K=4'b0000, en=1; model flop updates; done=1 exactly 3 cycles after accept; req_ready=1 the next cycle.
- Q_fb=4'b1111, target=4'b0110 -> J=4'b0000, K=4'b1001 in DRIVE. With JK_TOGGLE_DRIVE_EN: J=K=4'b1001.
- Q_fb held at 4'b0000 (flop stuck), target=4'b0001, TIMEOUT=3 -> 3 CHECK cycles, then err=1 for one cycle, done never asserted, back to IDLE.
- req_valid held high with target changing during DRIVE/CHECK -> only the accepted target is used; the next target is accepted only once req_ready=1 again.
- R asserted during the CHECK cycle -> next cycle IDLE, no done/err pulse, all outputs at reset values.
